// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide engine: one bit per clock, sign-fixed result on hi_out/lo_out.
// mult_div_done pulses for one cycle once the registered results are valid.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_div_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic              is_div, sa, sb;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    acc_hi;
    logic [WIDTH-1:0]  acc_lo;

    logic [CW-1:0]      count_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               borrow;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, src_a;

    assign count_next = count - 1'b1;

    // Multiply: acc_lo starts as |B| and is shifted out as the multiplier bits are consumed.
    assign mul_sum = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, mag_a} : '0);

    // Divide: acc_lo starts as |A|, shifts dividend bits into the remainder and quotient bits in.
    assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, mag_b};
    assign borrow    = div_trial[WIDTH+1];

    assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
    assign prod_fix = (sa ^ sb) ? -prod : prod;
    assign quot_fix = (sa ^ sb) ? -acc_lo : acc_lo;
    assign rem_fix  = sa ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    assign src_a    = sa ? -mag_a : mag_a;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            count         <= '0;
            is_div        <= 1'b0;
            sa            <= 1'b0;
            sb            <= 1'b0;
            mag_a         <= '0;
            mag_b         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            hi_out        <= '0;
            lo_out        <= '0;
            mult_div_done <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start || div_start) begin
                        is_div <= ~mult_start;
                        sa     <= SrcA[WIDTH-1];
                        sb     <= SrcB[WIDTH-1];
                        mag_a  <= SrcA[WIDTH-1] ? -SrcA : SrcA;
                        mag_b  <= SrcB[WIDTH-1] ? -SrcB : SrcB;
                        acc_hi <= '0;
                        acc_lo <= mult_start ? (SrcB[WIDTH-1] ? -SrcB : SrcB)
                                             : (SrcA[WIDTH-1] ? -SrcA : SrcA);
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= borrow ? div_shift : div_trial[WIDTH:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~borrow};
                    end else begin
                        acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    count <= count_next;
                    if (count_next == '0) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= prod_fix[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        hi_out <= src_a;
                        lo_out <= '1;
                    end else begin
                        hi_out <= rem_fix;
                        lo_out <= quot_fix;
                    end
                    mult_div_done <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    mult_div_done <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: table of signed mult/div cases plus
// sequences for simultaneous starts, starts while busy, and mid-operation reset.
module tb_mult_div_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic [31:0] hi_out, lo_out;
    logic        mult_div_done, busy;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .mult_start(mult_start), .div_start(div_start),
        .SrcA(SrcA), .SrcB(SrcB), .hi_out(hi_out), .lo_out(lo_out),
        .mult_div_done(mult_div_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start in cycle 0 (inputs driven mid-cycle), observe at each negedge; glitch>0 pulses
    // both starts with junk operands in that cycle of the operation.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int glitch, output int lat, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge CLK);
        chk("busy_before_start", {31'b0, busy}, 32'd0);
        mult_start = m; div_start = d; SrcA = a; SrcB = b;
        lat = -1; hi = '0; lo = '0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge CLK);
            mult_start = 1'b0; div_start = 1'b0;
            SrcA = $urandom; SrcB = $urandom;
            if (n == glitch) begin mult_start = 1'b1; div_start = 1'b1; end
            if (n == 1) chk("busy_cycle1", {31'b0, busy}, 32'd1);
            if (mult_div_done) begin
                lat = n; hi = hi_out; lo = lo_out;
                chk("busy_at_done", {31'b0, busy}, 32'd1);
            end
        end
        if (lat < 0) begin
            errors++; checks++;
            $display("FAIL done_timeout: no done within 60 cycles");
        end
        @(negedge CLK);
        chk("done_one_cycle", {31'b0, mult_div_done}, 32'd0);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] hi, lo;
        int seen;

        vecs[0]  = '{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{1, 0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2]  = '{1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{1, 0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[4]  = '{1, 0, 32'h8000_0000,  32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
        vecs[5]  = '{1, 0, 32'd0,          32'd12345,     32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{0, 1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[9]  = '{0, 1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[10] = '{0, 1, 32'd1234,       32'd0,         32'h0000_04D2, 32'hFFFF_FFFF};
        vecs[11] = '{0, 1, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[12] = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[13] = '{0, 1, 32'h8000_0000,  32'd2,         32'h0000_0000, 32'hC000_0000};
        vecs[14] = '{0, 1, 32'd3,          32'd10,        32'h0000_0003, 32'h0000_0000};
        vecs[15] = '{1, 0, 32'hFFFF_FFF0,  32'd16,        32'hFFFF_FFFF, 32'hFFFF_FF00};

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        chk("reset_done", {31'b0, mult_div_done}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 0, lat, hi, lo);
            chk($sformatf("v%0d_latency", i), lat, 32'd34);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // Both starts together -> multiply; a start pulse in cycle 10 is ignored.
        run_op(1'b1, 1'b1, 32'd5, 32'd3, 10, lat, hi, lo);
        chk("both_latency", lat, 32'd34);
        chk("both_hi", hi, 32'd0);
        chk("both_lo", lo, 32'h0000_000F);
        repeat (3) @(negedge CLK);
        chk("no_queued_done", {31'b0, mult_div_done | busy}, 32'd0);

        // Reset in cycle 15 of a divide abandons it with no done pulse.
        @(negedge CLK);
        div_start = 1'b1; SrcA = 32'd100; SrcB = 32'd7;
        for (int n = 1; n <= 15; n++) begin
            @(negedge CLK);
            div_start = 1'b0;
            if (n == 15) RST = 1'b1;
        end
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi_out, 32'd0);
        chk("rst_mid_lo", lo_out, 32'd0);
        chk("rst_mid_done", {31'b0, mult_div_done}, 32'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (mult_div_done || busy) seen++;
        end
        chk("rst_no_done_after", seen, 32'd0);

        run_op(1'b1, 1'b0, 32'd2, 32'd3, 0, lat, hi, lo);
        chk("post_rst_latency", lat, 32'd34);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
